// File: rtl/vliw_fetch_if.sv
// Fetch-stage bus: instruction-memory read port, pipeline control inputs and
// the bundle handed to decode. The fetch stage is the master side.
interface vliw_fetch_if #(
  parameter int PC_W     = 14,
  parameter int BUNDLE_W = 128
);
  logic [PC_W-1:0]     imem_addr;
  logic                imem_en;
  logic [BUNDLE_W-1:0] imem_rdata;
  logic                stall;
  logic                dec_stall;
  logic                flush;
  logic [PC_W-1:0]     redirect_pc;
  logic [BUNDLE_W-1:0] inst;
  logic [PC_W-1:0]     if_pc;
  logic                if_valid;

  modport master (
    output imem_addr, imem_en, inst, if_pc, if_valid,
    input  imem_rdata, stall, dec_stall, flush, redirect_pc
  );

  modport slave (
    input  imem_addr, imem_en, inst, if_pc, if_valid,
    output imem_rdata, stall, dec_stall, flush, redirect_pc
  );
endinterface

// File: rtl/vliw_fetch.sv
// Instruction fetch for the VLIW core: one bundle index per cycle into a
// synchronous imem, with a one-entry skid so holds never lose or repeat a bundle.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_EMPTY  | nothing in flight, nothing held (after reset / idle hold)
// S_STREAM | imem_rdata carries the bundle for opc_q this cycle
// S_HELD   | skid register holds the bundle being presented
module vliw_fetch #(
  parameter int PC_W     = 14,
  parameter int BUNDLE_W = 128,
  parameter int RESET_PC = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  vliw_fetch_if.master  bus
);

  typedef enum logic [1:0] {
    S_EMPTY  = 2'd0,
    S_STREAM = 2'd1,
    S_HELD   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [PC_W-1:0]     npc_q, npc_d;
  logic [PC_W-1:0]     opc_q, opc_d;
  logic [BUNDLE_W-1:0] sk_inst, sk_inst_d;
  logic [PC_W-1:0]     sk_pc, sk_pc_d;
  logic [PC_W-1:0]     addr_c;
  logic                en_c;
  logic                hold;

  assign hold = bus.stall | bus.dec_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_EMPTY;
      npc_q   <= PC_W'(RESET_PC);
      opc_q   <= '0;
      sk_inst <= '0;
      sk_pc   <= '0;
    end else begin
      state_q <= state_d;
      npc_q   <= npc_d;
      opc_q   <= opc_d;
      sk_inst <= sk_inst_d;
      sk_pc   <= sk_pc_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    npc_d     = npc_q;
    opc_d     = opc_q;
    sk_inst_d = sk_inst;
    sk_pc_d   = sk_pc;
    addr_c    = npc_q;
    en_c      = 1'b0;
    if (bus.flush) begin
      addr_c  = bus.redirect_pc;
      en_c    = 1'b1;
      opc_d   = bus.redirect_pc;
      npc_d   = bus.redirect_pc + PC_W'(1);
      state_d = S_STREAM;
    end else if (hold) begin
      // Only a bundle actually in flight is captured; an already-held one stays put.
      if (state_q == S_STREAM) begin
        sk_inst_d = bus.imem_rdata;
        sk_pc_d   = opc_q;
        state_d   = S_HELD;
      end
    end else begin
      en_c    = 1'b1;
      opc_d   = npc_q;
      npc_d   = npc_q + PC_W'(1);
      state_d = S_STREAM;
    end
  end

  assign bus.imem_addr = addr_c;
  assign bus.imem_en   = en_c & rst_n;

  // Driven from registered state and imem_rdata only, so decode can derive
  // dec_stall from inst without a loop.
  always_comb begin
    bus.inst     = '0;
    bus.if_pc    = '0;
    bus.if_valid = 1'b0;
    case (state_q)
      S_HELD: begin
        bus.inst     = sk_inst;
        bus.if_pc    = sk_pc;
        bus.if_valid = 1'b1;
      end
      S_STREAM: begin
        bus.inst     = bus.imem_rdata;
        bus.if_pc    = opc_q;
        bus.if_valid = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_vliw_fetch.sv
// Bench for vliw_fetch: directed per-cycle vectors feed a queue of expected
// presented PCs; a monitor pops and compares whenever if_valid is seen.
module tb_vliw_fetch;

  localparam int PC_W     = 14;
  localparam int BUNDLE_W = 128;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  bit   mon_en = 1'b1;

  int n_checks = 0;
  int n_fail   = 0;

  logic [PC_W-1:0] exp_q[$];

  typedef struct {
    logic            s, d, f;
    logic [PC_W-1:0] rpc;
    logic [PC_W-1:0] addr;
    logic            en;
    logic            ev;
    logic [PC_W-1:0] epc;
  } row_t;

  row_t rows[$];

  vliw_fetch_if #(.PC_W(PC_W), .BUNDLE_W(BUNDLE_W)) bus ();

  vliw_fetch #(.PC_W(PC_W), .BUNDLE_W(BUNDLE_W), .RESET_PC(0)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  function automatic logic [BUNDLE_W-1:0] bundle(input logic [PC_W-1:0] pc);
    logic [31:0] p;
    p = {18'b0, pc};
    return {32'h1000_0000 | p, 32'h2000_0000 | p, 32'h3000_0000 | p, 32'h4000_0000 | p};
  endfunction

  initial bus.imem_rdata = '0;
  always @(posedge clk)
    if (bus.imem_en) bus.imem_rdata <= bundle(bus.imem_addr);

  task automatic chk(input string nm, input logic [BUNDLE_W-1:0] act, input logic [BUNDLE_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Monitor: compare each presented bundle against the scoreboard queue.
  initial begin
    logic [PC_W-1:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (mon_en) begin
        if (bus.if_valid === 1'b1) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_valid at %0t: got if_pc %h expected no bundle", $time, bus.if_pc);
          end else begin
            e = exp_q.pop_front();
            chk("if_pc", {{(BUNDLE_W-PC_W){1'b0}}, bus.if_pc}, {{(BUNDLE_W-PC_W){1'b0}}, e});
            chk("inst", bus.inst, bundle(e));
          end
        end else begin
          chk("idle_inst", bus.inst, '0);
          chk("idle_if_pc", {{(BUNDLE_W-PC_W){1'b0}}, bus.if_pc}, '0);
        end
      end
    end
  end

  function automatic row_t mk(input logic s, d, f, input logic [PC_W-1:0] rpc,
                              input logic [PC_W-1:0] addr, input logic en,
                              input logic ev, input logic [PC_W-1:0] epc);
    row_t r;
    r.s = s; r.d = d; r.f = f; r.rpc = rpc;
    r.addr = addr; r.en = en; r.ev = ev; r.epc = epc;
    return r;
  endfunction

  task automatic drive_row(input row_t r);
    if (r.ev) exp_q.push_back(r.epc);
    bus.stall       = r.s;
    bus.dec_stall   = r.d;
    bus.flush       = r.f;
    bus.redirect_pc = r.rpc;
    #1;
    chk("imem_addr", {{(BUNDLE_W-PC_W){1'b0}}, bus.imem_addr}, {{(BUNDLE_W-PC_W){1'b0}}, r.addr});
    chk("imem_en", {{(BUNDLE_W-1){1'b0}}, bus.imem_en}, {{(BUNDLE_W-1){1'b0}}, r.en});
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_if_valid"}, {{(BUNDLE_W-1){1'b0}}, bus.if_valid}, '0);
    chk({tag, "_inst"}, bus.inst, '0);
    chk({tag, "_if_pc"}, {{(BUNDLE_W-PC_W){1'b0}}, bus.if_pc}, '0);
    chk({tag, "_imem_en"}, {{(BUNDLE_W-1){1'b0}}, bus.imem_en}, '0);
  endtask

  initial begin
    bus.stall       = 1'b0;
    bus.dec_stall   = 1'b0;
    bus.flush       = 1'b0;
    bus.redirect_pc = '0;

    // s d f rpc addr en ev epc -- epc is what is presented during that cycle
    rows.push_back(mk(0,0,0, 14'h0,    14'h000, 1, 0, 14'h000));
    rows.push_back(mk(0,0,0, 14'h0,    14'h001, 1, 1, 14'h000));
    rows.push_back(mk(0,0,0, 14'h0,    14'h002, 1, 1, 14'h001));
    rows.push_back(mk(0,0,0, 14'h0,    14'h003, 1, 1, 14'h002));
    rows.push_back(mk(0,0,0, 14'h0,    14'h004, 1, 1, 14'h003));
    rows.push_back(mk(0,0,0, 14'h0,    14'h005, 1, 1, 14'h004));
    rows.push_back(mk(1,0,0, 14'h0,    14'h006, 0, 1, 14'h005));
    rows.push_back(mk(1,0,0, 14'h0,    14'h006, 0, 1, 14'h005));
    rows.push_back(mk(0,0,0, 14'h0,    14'h006, 1, 1, 14'h005));
    rows.push_back(mk(0,0,0, 14'h0,    14'h007, 1, 1, 14'h006));
    rows.push_back(mk(0,0,0, 14'h0,    14'h008, 1, 1, 14'h007));
    rows.push_back(mk(0,0,0, 14'h0,    14'h009, 1, 1, 14'h008));
    rows.push_back(mk(0,1,0, 14'h0,    14'h00A, 0, 1, 14'h009));
    rows.push_back(mk(1,0,0, 14'h0,    14'h00A, 0, 1, 14'h009));
    rows.push_back(mk(0,0,0, 14'h0,    14'h00A, 1, 1, 14'h009));
    rows.push_back(mk(0,0,0, 14'h0,    14'h00B, 1, 1, 14'h00A));
    rows.push_back(mk(0,0,1, 14'h120,  14'h120, 1, 1, 14'h00B));
    rows.push_back(mk(0,0,0, 14'h0,    14'h121, 1, 1, 14'h120));
    rows.push_back(mk(0,0,0, 14'h0,    14'h122, 1, 1, 14'h121));
    rows.push_back(mk(1,0,0, 14'h0,    14'h123, 0, 1, 14'h122));
    rows.push_back(mk(1,0,1, 14'h120,  14'h120, 1, 1, 14'h122));
    rows.push_back(mk(0,0,0, 14'h0,    14'h121, 1, 1, 14'h120));
    rows.push_back(mk(0,0,0, 14'h0,    14'h122, 1, 1, 14'h121));
    rows.push_back(mk(0,0,1, 14'h3FFE, 14'h3FFE,1, 1, 14'h122));
    rows.push_back(mk(0,0,0, 14'h0,    14'h3FFF,1, 1, 14'h3FFE));
    rows.push_back(mk(0,0,0, 14'h0,    14'h000, 1, 1, 14'h3FFF));
    rows.push_back(mk(0,0,0, 14'h0,    14'h001, 1, 1, 14'h000));
    rows.push_back(mk(0,0,0, 14'h0,    14'h002, 1, 1, 14'h001));
    rows.push_back(mk(1,0,0, 14'h0,    14'h003, 0, 1, 14'h002));

    #3;
    check_reset_outputs("reset");
    chk("reset_imem_addr", {{(BUNDLE_W-PC_W){1'b0}}, bus.imem_addr}, '0);

    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    foreach (rows[i]) begin
      drive_row(rows[i]);
      @(negedge clk);
    end

    // Second held cycle of bundle 2; reset lands mid-cycle with the skid full.
    drive_row(mk(1,0,0, 14'h0, 14'h003, 0, 1, 14'h002));
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    @(negedge clk);
    @(negedge clk);
    bus.stall = 1'b0;
    rst_n = 1'b1;
    drive_row(mk(0,0,0, 14'h0, 14'h000, 1, 0, 14'h000));
    @(negedge clk);
    drive_row(mk(0,0,0, 14'h0, 14'h001, 1, 1, 14'h000));
    @(negedge clk);
    drive_row(mk(0,0,0, 14'h0, 14'h002, 1, 1, 14'h001));
    @(negedge clk);
    drive_row(mk(0,0,0, 14'h0, 14'h003, 1, 1, 14'h002));
    @(negedge clk);
    mon_en = 1'b0;

    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d bundles never presented expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
